// File: rtl/park_transform.sv
// park_transform: Clarke + Park transform of two phase currents into d/q
// currents. A single signed 18x16 multiplier is time-shared over five
// products, which are sequenced by a small FSM into a 36-bit accumulator.
// A result is produced 6 clocks after the start strobe. A new strobe can be
// accepted on the clock edge that ends the oDone cycle, so back-to-back
// conversions complete one every 7 clocks.
module park_transform #(
    parameter int unsigned INV_SQRT3 = 18919
) (
    input  logic               iClk,
    input  logic               iRst,
    input  logic               iEn,
    input  logic signed [15:0] iIa,
    input  logic signed [15:0] iIb,
    input  logic signed [15:0] iSin,
    input  logic signed [15:0] iCos,
    output logic signed [15:0] oId,
    output logic signed [15:0] oIq,
    output logic               oBusy,
    output logic               oDone
);

    // FSM encoding: one state per clock; products are formed in BETA and M0..M3.
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_BETA = 3'd1;
    localparam logic [2:0] ST_M0   = 3'd2;
    localparam logic [2:0] ST_M1   = 3'd3;
    localparam logic [2:0] ST_M2   = 3'd4;
    localparam logic [2:0] ST_M3   = 3'd5;
    localparam logic [2:0] ST_OUT  = 3'd6;

    // 1/sqrt(3) in Q0.15 is always below 1.0, so it fits a signed 16-bit operand.
    localparam logic signed [15:0] K_INV_SQRT3 = 16'(INV_SQRT3);

    localparam logic signed [35:0] SAT_MAX = 36'sd32767;
    localparam logic signed [35:0] SAT_MIN = -36'sd32768;

    logic [2:0]         state_r;
    logic signed [15:0] ia_r;
    logic signed [15:0] ib_r;
    logic signed [15:0] sin_r;
    logic signed [15:0] cos_r;
    logic signed [15:0] beta_r;
    logic signed [15:0] id_r;
    logic signed [15:0] iq_r;
    logic signed [35:0] acc_r;

    logic signed [17:0] clarke_sum;
    logic signed [17:0] alpha_ext;
    logic signed [17:0] beta_ext;
    logic signed [17:0] mul_a;
    logic signed [15:0] mul_b;
    logic signed [33:0] product;
    logic signed [35:0] prod_ext;
    logic signed [35:0] acc_sum;
    logic signed [35:0] acc_diff;

    // Clamp a wide signed value into the 16-bit signed output range.
    function automatic logic signed [15:0] sat16(input logic signed [35:0] v);
        logic signed [15:0] r;
        if (v > SAT_MAX) begin
            r = 16'sh7FFF;
        end else if (v < SAT_MIN) begin
            r = 16'sh8000;
        end else begin
            r = v[15:0];
        end
        return r;
    endfunction

    // Ia + 2*Ib needs 18 bits so that full-scale inputs cannot wrap before the scaling multiply.
    assign clarke_sum = {{2{ia_r[15]}}, ia_r} + {ib_r[15], ib_r, 1'b0};
    assign alpha_ext  = {{2{ia_r[15]}}, ia_r};
    assign beta_ext   = {{2{beta_r[15]}}, beta_r};

    // Operand steering for the shared multiplier: each state selects the pair of factors it needs.
    always_comb begin
        mul_a = 18'sd0;
        mul_b = 16'sd0;
        case (state_r)
            ST_BETA: begin
                mul_a = clarke_sum;
                mul_b = K_INV_SQRT3;
            end
            ST_M0: begin
                mul_a = alpha_ext;
                mul_b = cos_r;
            end
            ST_M1: begin
                mul_a = beta_ext;
                mul_b = sin_r;
            end
            ST_M2: begin
                mul_a = beta_ext;
                mul_b = cos_r;
            end
            ST_M3: begin
                mul_a = alpha_ext;
                mul_b = sin_r;
            end
            default: begin
                mul_a = 18'sd0;
                mul_b = 16'sd0;
            end
        endcase
    end

    assign product  = mul_a * mul_b;
    assign prod_ext = {{2{product[33]}}, product};
    assign acc_sum  = acc_r + prod_ext;
    assign acc_diff = acc_r - prod_ext;

    // Conversion sequencer: sample on an accepted strobe, step through the products, then publish results.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_r <= ST_IDLE;
            ia_r    <= '0;
            ib_r    <= '0;
            sin_r   <= '0;
            cos_r   <= '0;
            beta_r  <= '0;
            id_r    <= '0;
            iq_r    <= '0;
            acc_r   <= '0;
            oId     <= '0;
            oIq     <= '0;
            oBusy   <= 1'b0;
            oDone   <= 1'b0;
        end else begin
            oDone <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    oBusy <= iEn;
                    if (iEn) begin
                        ia_r    <= iIa;
                        ib_r    <= iIb;
                        sin_r   <= iSin;
                        cos_r   <= iCos;
                        state_r <= ST_BETA;
                    end
                end
                ST_BETA: begin
                    beta_r  <= sat16(prod_ext >>> 15);
                    state_r <= ST_M0;
                end
                ST_M0: begin
                    acc_r   <= prod_ext;
                    state_r <= ST_M1;
                end
                ST_M1: begin
                    acc_r   <= acc_sum;
                    id_r    <= sat16(acc_sum >>> 15);
                    state_r <= ST_M2;
                end
                ST_M2: begin
                    acc_r   <= prod_ext;
                    state_r <= ST_M3;
                end
                ST_M3: begin
                    acc_r   <= acc_diff;
                    iq_r    <= sat16(acc_diff >>> 15);
                    state_r <= ST_OUT;
                end
                ST_OUT: begin
                    oId     <= id_r;
                    oIq     <= iq_r;
                    oDone   <= 1'b1;
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                    oBusy   <= 1'b0;
                end
            endcase
        end
    end

endmodule
